// File: rtl/diff_frame_decoder.sv
// Differential (toggle-on-1) line decoder with sync hunt, fixed-length payload
// deframing and trailing XOR checksum check.
module diff_frame_decoder #(
  parameter logic [7:0]  SYNC          = 8'hA5,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       sync_lock,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {StHunt, StData, StCheck} state_e;

  localparam logic [3:0] LastByte = 4'(PAYLOAD_BYTES - 1);

  state_e     state_q, state_d;
  logic       prev_q, prev_d;
  logic [7:0] sreg_q, sreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [3:0] bytecnt_q, bytecnt_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       sync_lock_q, sync_lock_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;

  logic       rx_bit;
  logic [7:0] shifted;

  assign rx_bit  = din ^ prev_q;
  assign shifted = {sreg_q[6:0], rx_bit};

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    sreg_d       = sreg_q;
    bitcnt_d     = bitcnt_q;
    bytecnt_d    = bytecnt_q;
    chk_d        = chk_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_lock_d  = sync_lock_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;

    if (din_valid) begin
      prev_d = din;
      sreg_d = shifted;
      case (state_q)
        StHunt: begin
          if (shifted == SYNC) begin
            state_d     = StData;
            bitcnt_d    = 3'd0;
            bytecnt_d   = 4'd0;
            chk_d       = 8'h00;
            sync_lock_d = 1'b1;
          end
        end
        StData: begin
          // 3-bit counter wraps to 0 on the 8th bit by itself
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            dout_d       = shifted;
            dout_valid_d = 1'b1;
            chk_d        = chk_q ^ shifted;
            bytecnt_d    = bytecnt_q + 4'd1;
            if (bytecnt_q == LastByte) begin
              state_d = StCheck;
            end
          end
        end
        StCheck: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            frame_done_d = 1'b1;
            frame_err_d  = (shifted != chk_q);
            sync_lock_d  = 1'b0;
            state_d      = StHunt;
            // Force a complete fresh sync byte before the next frame
            sreg_d       = 8'h00;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StHunt;
      prev_q       <= 1'b0;
      sreg_q       <= 8'h00;
      bitcnt_q     <= 3'd0;
      bytecnt_q    <= 4'd0;
      chk_q        <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      sync_lock_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      sreg_q       <= sreg_d;
      bitcnt_q     <= bitcnt_d;
      bytecnt_q    <= bytecnt_d;
      chk_q        <= chk_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_lock_q  <= sync_lock_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_lock  = sync_lock_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_diff_frame_decoder.sv
// Table-driven bench for diff_frame_decoder: a bench-side differential encoder
// drives framed payloads; outputs are compared against hand-computed values.
module tb_diff_frame_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       sync_lock;
  logic       frame_done;
  logic       frame_err;

  diff_frame_decoder #(
    .SYNC         (8'hA5),
    .PAYLOAD_BYTES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .sync_lock (sync_lock),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pay;      // payload bytes, first-sent in bits 31:24
    logic [7:0]  ck;       // checksum byte as transmitted
    bit          gaps;     // insert random din_valid=0 cycles
    logic        exp_err;  // hand-computed checksum verdict
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          frame_idx;
  logic        level;
  logic [7:0]  got_q[$];
  int          got_cyc[$];
  int          done_cnt;
  logic        last_err;
  logic        prev_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (frame %0d): got %0h expected %0h", name, frame_idx, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic line, input logic v);
    @(negedge clk);
    din       = line;
    din_valid = v;
    @(posedge clk);
    #1;
    cyc++;
    if (dout_valid) begin
      got_q.push_back(dout);
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      last_err = frame_err;
    end
    if (!v) check("no_pulse_in_gap", 32'({dout_valid, frame_done}), 32'd0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(~level, 1'b0);
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) gap(int'($urandom_range(1, 2)));
    level = level ^ b;
    step(level, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    din       = ~level;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    check("reset_outputs", 32'({dout, dout_valid, sync_lock, frame_done, frame_err}), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held", 32'({dout, dout_valid, sync_lock, frame_done, frame_err}), 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    level     = 1'b0;
    prev_err  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0;
    send_byte(8'hA5, v.gaps);
    if (v.gaps) gap(3);
    check("sync_lock_after_sync", 32'(sync_lock), 32'd1);
    for (int b = 3; b >= 0; b--) send_byte(v.pay[b*8 +: 8], v.gaps);
    check("frame_err_held", 32'(frame_err), 32'(prev_err));
    check("dout_holds_last", 32'(dout), 32'(v.pay[7:0]));
    send_byte(v.ck, v.gaps);
    check("frame_done_now", 32'(frame_done), 32'd1);
    check("frame_done_count", 32'(done_cnt), 32'd1);
    check("frame_err", 32'(last_err), 32'(v.exp_err));
    check("sync_lock_released", 32'(sync_lock), 32'd0);
    check("dout_valid_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        check("dout_byte", 32'(got_q[b]), 32'(v.pay[(3-b)*8 +: 8]));
        if (!v.gaps && b > 0) check("pulse_spacing", 32'(got_cyc[b] - got_cyc[b-1]), 32'd8);
      end
    end
    prev_err = v.exp_err;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{pay: 32'h01020304, ck: 8'h04, gaps: 1'b0, exp_err: 1'b0};
    vecs[1] = '{pay: 32'h01020304, ck: 8'h05, gaps: 1'b0, exp_err: 1'b1};
    vecs[2] = '{pay: 32'h01020304, ck: 8'h04, gaps: 1'b0, exp_err: 1'b0};
    vecs[3] = '{pay: 32'h01020304, ck: 8'h04, gaps: 1'b1, exp_err: 1'b0};
    vecs[4] = '{pay: 32'h11A52233, ck: 8'hA5, gaps: 1'b0, exp_err: 1'b0};
    vecs[5] = '{pay: 32'hDEADBEEF, ck: 8'h22, gaps: 1'b0, exp_err: 1'b0};
    vecs[6] = '{pay: 32'h80FF0001, ck: 8'h7E, gaps: 1'b0, exp_err: 1'b0};
    vecs[7] = '{pay: 32'h00000000, ck: 8'h01, gaps: 1'b0, exp_err: 1'b1};
    vecs[8] = '{pay: 32'h00000000, ck: 8'h00, gaps: 1'b0, exp_err: 1'b0};

    rst       = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    level     = 1'b0;
    frame_idx = -1;
    done_cnt  = 0;
    last_err  = 1'b0;
    prev_err  = 1'b0;
    do_reset();

    // Sync only: line levels 1,1,0,0,0,1,1,0 decode to A5 from a 0 start level.
    got_q.delete();
    for (int i = 7; i >= 1; i--) send_bit(8'hA5 >> i, 1'b0);
    check("sync_lock_before_8th", 32'(sync_lock), 32'd0);
    send_bit(1'b1, 1'b0);
    check("sync_lock_after_8th", 32'(sync_lock), 32'd1);
    check("no_dout_on_sync", 32'(got_q.size()), 32'd0);
    do_reset();

    // Frames sent back to back with no idle bits between them.
    for (int f = 0; f < 9; f++) begin
      frame_idx = f;
      run_frame(vecs[f]);
    end

    // Abort after payload byte 2, then a fresh frame from a reset line level.
    frame_idx = 9;
    got_q.delete();
    done_cnt = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check("abort_bytes_seen", 32'(got_q.size()), 32'd2);
    if (level == 1'b0) send_bit(1'b1, 1'b0);
    do_reset();
    check("abort_no_frame_done", 32'(done_cnt), 32'd0);
    frame_idx = 10;
    run_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/diff_frame_decoder.md
Name: diff_frame_decoder

Overview:
Receive-side counterpart of the team's differential (toggle-on-1) bit encoder. The encoder's line level flips whenever the source bit is 1 and holds when it is 0. This block recovers source bits as the XOR of consecutive line levels. It then hunts for a sync byte, deframes a fixed-length payload MSB-first, presents each byte with a one-cycle valid pulse, and checks a trailing XOR checksum byte.

Parameters:
SYNC, 8'hA5, decoded sync byte that starts a frame
PAYLOAD_BYTES, 4, payload bytes per frame (legal range 1..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
din  input  1  encoded line level
din_valid  input  1  din is sampled only on cycles where this is 1
dout  output  8  last completed payload byte
dout_valid  output  1  one-cycle pulse, dout updated
sync_lock  output  1  high while a frame is in progress (DATA or CHECK state)
frame_done  output  1  one-cycle pulse when the checksum byte completes
frame_err  output  1  valid with frame_done: 1 = checksum mismatch; held until next frame_done

Behaviour:
- Interface: reset is rst, synchronous, active-low; clock is clk.
- Reset (rst=0 at a clock edge):
  - state=HUNT; prev_level=0 (matches the encoder's reset line level of 0).
  - Shift register, bit/byte counters and checksum cleared.
  - dout=0, dout_valid=0, sync_lock=0, frame_done=0, frame_err=0.
  - Reset mid-frame discards the partial frame; no pulses are emitted.
- Decode, on a cycle with din_valid=1:
  - bit = din ^ prev_level; prev_level <= din.
- din_valid=0: no state, counter, register or prev_level change. Pulse outputs still drop to 0 after one cycle.
- All outputs are registered. Pulses assert in the cycle after the clock edge that sampled the completing bit.
- FSM states: HUNT, DATA, CHECK.
- HUNT:
  - sreg <= {sreg[6:0], bit}.
  - If {sreg[6:0], bit} == SYNC: go to DATA, bitcnt=0, bytecnt=0, chk=0, sync_lock<=1.
- DATA:
  - Shift bit into byte register MSB-first; bitcnt increments.
  - On the 8th bit: dout<=byte, dout_valid<=1, chk<=chk^byte, bitcnt wraps to 0, bytecnt increments.
  - When bytecnt reaches PAYLOAD_BYTES: go to CHECK.
- CHECK:
  - Collect 8 bits.
  - On the 8th bit: frame_done<=1, frame_err<=(byte != chk), sync_lock<=0, go to HUNT, sreg<=0.
  - The checksum byte is not output on dout; dout_valid stays 0.
- Sync and data boundaries:
  - Sync detection is disabled in DATA and CHECK, so a SYNC value inside the payload is treated as data.
  - Clearing sreg on frame end requires a full fresh 8-bit sync.
  - Back-to-back frames are supported with no idle bits.
- Gaps: any number of din_valid=0 cycles may occur between bits, including mid-byte. Decoding resumes correctly because prev_level is held.
- dout holds its value between pulses.
- frame_err holds between frame_done pulses.
- Minimum spacing between dout_valid pulses is 8 cycles.

Test Plan:
1. Reset, then drive encoded sync 1,1,0,0,0,1,1,0 (decodes to A5 from prev_level 0) -> sync_lock=1 the cycle after the 8th bit. dout_valid stays 0.
2. Full frame with payload 01,02,03,04 and checksum 04, each bit's line level = previous level XOR data bit -> four dout_valid pulses with dout 01,02,03,04, 8 cycles apart. Then frame_done=1, frame_err=0, sync_lock=0.
3. Same frame with checksum 05 -> frame_done=1, frame_err=1. Next frame with a correct checksum -> frame_err returns to 0.
4. Same frame with random din_valid=0 gaps (including mid-byte and between sync and payload) -> identical dout sequence and frame_err=0. No pulse occurs during gap cycles.
5. Payload containing A5 followed by a second back-to-back frame -> A5 is output as data. The second frame is decoded correctly, and exactly two frame_done pulses occur.
6. rst=0 after payload byte 2 of a frame, then a complete fresh frame -> no pulses for the aborted frame. All outputs are 0 during reset, and the fresh frame decodes correctly with prev_level restarting at 0.
